// File: rtl/alu_cmd_issuer.sv
// Clocked initiator for the combinational ALU. Commands are queued in a small FIFO,
// issued to the ALU one at a time, and each result is returned over a valid/ready response port.
module alu_cmd_issuer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_in1,
    input  logic [WIDTH-1:0]     cmd_in2,
    input  logic [3:0]           cmd_op,
    output logic [WIDTH-1:0]     alu_in1,
    output logic [WIDTH-1:0]     alu_in2,
    output logic [3:0]           alu_op,
    output logic                 alu_invalid_data,
    input  logic [2*WIDTH-1:0]   alu_out,
    input  logic                 alu_zero,
    input  logic                 alu_error,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_error,
    output logic [7:0]           err_count
);

    localparam int unsigned OP_W    = 4;
    localparam int unsigned ENT_W   = 2 * WIDTH + OP_W;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ERR_W   = 8;
    localparam logic [OP_W-1:0]  LAST_OP = OP_W'(3);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t state;

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;
    logic [WIDTH-1:0] head_in1;
    logic [WIDTH-1:0] head_in2;
    logic [OP_W-1:0]  head_op;

    // Ready drops with reset so no command is offered into a cycle that will discard it.
    assign fifo_empty = (count == '0);
    assign cmd_ready  = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = !fifo_empty &&
                        ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));

    assign head     = fifo_mem[rd_ptr];
    assign head_in1 = head[ENT_W-1 -: WIDTH];
    assign head_in2 = head[OP_W +: WIDTH];
    assign head_op  = head[OP_W-1:0];

    // Command storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_in1, cmd_in2, cmd_op};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Issue/response sequencer; a pop loads the ALU operand registers in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            alu_in1          <= '0;
            alu_in2          <= '0;
            alu_op           <= '0;
            alu_invalid_data <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            rsp_zero         <= 1'b0;
            rsp_error        <= 1'b0;
            err_count        <= '0;
        end else begin
            alu_invalid_data <= 1'b0;

            if (pop) begin
                alu_in1          <= head_in1;
                alu_in2          <= head_in2;
                alu_op           <= head_op;
                alu_invalid_data <= (head_op > LAST_OP);
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rsp_valid <= 1'b1;
                    if (alu_invalid_data) begin
                        rsp_data  <= '1;
                        rsp_zero  <= 1'b0;
                        rsp_error <= 1'b1;
                    end else begin
                        rsp_data  <= alu_out;
                        rsp_zero  <= alu_zero;
                        rsp_error <= alu_error;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_error && (err_count != ERR_MAX)) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        state <= pop ? S_ISSUE : S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU, table-driven vectors and a response scoreboard,
// plus hand sequences for latency, spacing, backpressure, saturation and mid-run reset.
module tb_alu_cmd_issuer;

    localparam int unsigned W  = 8;
    localparam int unsigned RW = 2 * W;

    typedef struct {
        logic [W-1:0]  in1;
        logic [W-1:0]  in2;
        logic [3:0]    op;
        logic [RW-1:0] data;
        logic          zero;
        logic          err;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_in1;
    logic [W-1:0]  cmd_in2;
    logic [3:0]    cmd_op;
    logic [W-1:0]  alu_in1;
    logic [W-1:0]  alu_in2;
    logic [3:0]    alu_op;
    logic          alu_invalid_data;
    logic [RW-1:0] alu_out;
    logic          alu_zero;
    logic          alu_error;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_data;
    logic          rsp_zero;
    logic          rsp_error;
    logic [7:0]    err_count;

    alu_cmd_issuer #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_in1          (cmd_in1),
        .cmd_in2          (cmd_in2),
        .cmd_op           (cmd_op),
        .alu_in1          (alu_in1),
        .alu_in2          (alu_in2),
        .alu_op           (alu_op),
        .alu_invalid_data (alu_invalid_data),
        .alu_out          (alu_out),
        .alu_zero         (alu_zero),
        .alu_error        (alu_error),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_zero         (rsp_zero),
        .rsp_error        (rsp_error),
        .err_count        (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unsupported ops return junk so forcing in the DUT is observable.
    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    always_comb begin
        a_ext     = {{W{alu_in1[W-1]}}, alu_in1};
        b_ext     = {{W{alu_in2[W-1]}}, alu_in2};
        alu_out   = 16'h5A5A;
        alu_zero  = 1'b1;
        alu_error = 1'b0;
        case (alu_op)
            4'd0: alu_out = a_ext + b_ext;
            4'd1: alu_out = a_ext - b_ext;
            4'd2: alu_out = a_ext * b_ext;
            4'd3: begin
                if (b_ext == '0) begin
                    alu_out   = '1;
                    alu_error = 1'b1;
                end else begin
                    alu_out = a_ext / b_ext;
                end
            end
            default: ;
        endcase
        if (alu_op <= 4'd3) alu_zero = (alu_out == '0);
    end

    int   n_chk;
    int   n_fail;
    int   cyc;
    int   n_rsp;
    int   exp_errs;
    vec_t sb[$];
    int   rsp_cycles[$];
    logic stall;
    logic [RW-1:0] held_data;
    logic held_zero;
    logic held_err;
    vec_t tbl[13];

    function automatic vec_t mk(input int in1, input int in2, input int op,
                                input int data, input int z, input int e);
        vec_t v;
        v.in1  = W'(in1);
        v.in2  = W'(in2);
        v.op   = 4'(op);
        v.data = RW'(data);
        v.zero = 1'(z);
        v.err  = 1'(e);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and hold check, evaluated with this cycle's final inputs before the edge.
    task automatic mon_step();
        vec_t e;
        if (rst) begin
            stall = 1'b0;
            return;
        end
        if (stall) begin
            chk("rsp_hold_data", 32'(rsp_data), 32'(held_data));
            chk("rsp_hold_flags", 32'({rsp_valid, rsp_zero, rsp_error}),
                32'({1'b1, held_zero, held_err}));
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL stale_rsp: got data %0h with nothing outstanding", rsp_data);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                chk("rsp_error", 32'(rsp_error), 32'(e.err));
                if (e.err && exp_errs < 255) exp_errs++;
                n_rsp++;
                rsp_cycles.push_back(cyc);
            end
        end
        stall     = rsp_valid && !rsp_ready;
        held_data = rsp_data;
        held_zero = rsp_zero;
        held_err  = rsp_error;
    endtask

    task automatic tick();
        mon_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic push_cmd(input vec_t v);
        int waited;
        waited    = 0;
        cmd_in1   = v.in1;
        cmd_in2   = v.in2;
        cmd_op    = v.op;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: cmd_ready got 0 expected 1 after %0d cycles", waited);
            cmd_valid = 1'b0;
            return;
        end
        sb.push_back(v);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || rsp_valid) && w < 500) begin
            tick();
            w++;
        end
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
    endtask

    task automatic bp_step(input int n_acc_in, output int n_acc_out);
        n_acc_out = n_acc_in;
        if (n_acc_in < 6) begin
            cmd_in1   = tbl[n_acc_in].in1;
            cmd_in2   = tbl[n_acc_in].in2;
            cmd_op    = tbl[n_acc_in].op;
            cmd_valid = 1'b1;
        end else begin
            cmd_valid = 1'b0;
        end
        if (cmd_valid && cmd_ready) begin
            sb.push_back(tbl[n_acc_in]);
            n_acc_out = n_acc_in + 1;
        end
        tick();
    endtask

    initial begin
        int n_acc;
        int n_rsp0;
        int guard;
        logic seen;

        n_chk = 0; n_fail = 0; cyc = 0; n_rsp = 0; exp_errs = 0; stall = 1'b0;
        held_data = '0; held_zero = 1'b0; held_err = 1'b0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_in1 = '0; cmd_in2 = '0; cmd_op = '0;
        rsp_ready = 1'b0;

        tbl[0]  = mk(5, -3, 0, 'h0002, 0, 0);
        tbl[1]  = mk(4, 4, 1, 'h0000, 1, 0);
        tbl[2]  = mk(-128, -128, 2, 'h4000, 0, 0);
        tbl[3]  = mk(7, 0, 3, 'hFFFF, 0, 1);
        tbl[4]  = mk(-9, 2, 3, 'hFFFC, 0, 0);
        tbl[5]  = mk(1, 2, 9, 'hFFFF, 0, 1);
        tbl[6]  = mk(127, 127, 0, 'h00FE, 0, 0);
        tbl[7]  = mk(-128, 127, 1, 'hFF01, 0, 0);
        tbl[8]  = mk(127, -128, 2, 'hC080, 0, 0);
        tbl[9]  = mk(0, -5, 2, 'h0000, 1, 0);
        tbl[10] = mk(0, 0, 15, 'hFFFF, 0, 1);
        tbl[11] = mk(-128, -1, 3, 'h0080, 0, 0);
        tbl[12] = mk(100, 7, 3, 'h000E, 0, 0);

        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_zero, rsp_error}), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_alu_ops", 32'({alu_in1, alu_in2, alu_op}), 32'd0);
        chk("rst_alu_invalid", 32'(alu_invalid_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Minimum latency: valid on the third cycle after acceptance.
        rsp_ready = 1'b1;
        push_cmd(tbl[0]);
        chk("lat_cycle1_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat_issue_valid", 32'(rsp_valid), 32'd0);
        chk("lat_issue_alu_in", 32'({alu_in1, alu_in2, alu_op}), 32'({8'd5, 8'hFD, 4'd0}));
        chk("lat_issue_invalid", 32'(alu_invalid_data), 32'd0);
        tick();
        chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
        drain();

        // Back-to-back sub then mul: responses two cycles apart.
        rsp_cycles.delete();
        push_cmd(tbl[1]);
        push_cmd(tbl[2]);
        drain();
        chk("b2b_rsp_count", 32'(rsp_cycles.size()), 32'd2);
        if (rsp_cycles.size() == 2)
            chk("b2b_spacing", 32'(rsp_cycles[1] - rsp_cycles[0]), 32'd2);

        // Divide by zero then a normal signed divide.
        push_cmd(tbl[3]);
        drain();
        chk("div0_err_count", 32'(err_count), 32'd1);
        push_cmd(tbl[4]);
        drain();
        chk("div_err_count", 32'(err_count), 32'd1);

        // Unsupported op: invalid flag only while issuing.
        push_cmd(mk(3, 4, 9, 'hFFFF, 0, 1));
        chk("op9_pre_invalid", 32'(alu_invalid_data), 32'd0);
        tick();
        chk("op9_issue_invalid", 32'(alu_invalid_data), 32'd1);
        chk("op9_issue_alu", 32'({alu_in1, alu_op}), 32'({8'd3, 4'd9}));
        tick();
        chk("op9_resp_invalid", 32'(alu_invalid_data), 32'd0);
        chk("op9_resp_alu_op_held", 32'(alu_op), 32'd9);
        drain();

        for (int i = 0; i < 13; i++) push_cmd(tbl[i]);
        drain();
        chk("table_err_count", 32'(err_count), 32'(exp_errs));
        chk("table_err_count_abs", 32'(err_count), 32'd5);

        // Backpressure: five accepted while the response port is stalled.
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 20; c++) bp_step(n_acc, n_acc);
        chk("bp_accepted", 32'(n_acc), 32'd5);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        n_rsp0 = n_rsp;
        rsp_ready = 1'b1;
        guard = 0;
        while (n_acc < 6 && guard < 50) begin
            bp_step(n_acc, n_acc);
            guard++;
        end
        cmd_valid = 1'b0;
        chk("bp_sixth_accepted", 32'(n_acc), 32'd6);
        drain();
        chk("bp_rsp_count", 32'(n_rsp - n_rsp0), 32'd6);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) push_cmd(mk(i, 1, 12, 'hFFFF, 0, 1));
        drain();
        chk("err_count_saturate", 32'(err_count), 32'd255);

        // Reset while a response is pending and three commands are queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(tbl[i]);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pre_rst_err_count", 32'(err_count), 32'd255);
        rst = 1'b1;
        sb.delete();
        exp_errs = 0;
        tick();
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_stale_rsp", 32'(seen), 32'd0);
        push_cmd(tbl[0]);
        drain();
        chk("post_rst_err_count", 32'(err_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
